bsg_async_rptr_ctrl: RTL and testbench
======================================

Name: bsg_async_rptr_ctrl

Overview:
- Read-side pointer controller for the dual-clock FIFO. It is the counterpart of the write-side gray pointer generator.
- Runs entirely in the read clock domain. Consumes the write pointer, which arrives gray-coded and already double-synchronized into this domain.
- Keeps the read pointer in binary and gray form and produces valid, occupancy, read address and an error flag.
- The registered gray read pointer is exported for synchronization back to the write domain.

Parameters:
- lg_size_p, 4, log2 of FIFO depth. Pointer width is ptr_w = lg_size_p+1.

Ports:
- clk_i  in  1  read-domain clock.
- reset_i  in  1  reset; asynchronous, active-high.
- w_ptr_gray_rsync_i  in  ptr_w  write pointer, gray-coded, already synchronized to clk_i.
- yumi_i  in  1  consumer takes the head entry this cycle; legal only when v_o=1.
- v_o  out  1  FIFO non-empty; head entry valid at r_addr_o.
- r_addr_o  out  lg_size_p  memory read address, equal to r_ptr_binary_r_o[lg_size_p-1:0].
- r_ptr_binary_r_o  out  ptr_w  registered binary read pointer.
- r_ptr_gray_r_o  out  ptr_w  registered gray read pointer, for crossing to the write domain.
- count_o  out  ptr_w  occupancy, range 0..2^lg_size_p.
- error_o  out  1  sticky protocol/consistency error.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset (asynchronous, takes effect without a clock edge):
  - r_ptr_binary_r = 0, r_ptr_p1_r = 1, r_ptr_gray_r = 0, error_r = 0.
  - Outputs follow from these registers and w_ptr_gray_rsync_i.
- Reset deasserted mid-operation: pointers restart from 0. No state survives reset.
- Internal registers: r_ptr_binary_r, r_ptr_p1_r (binary pointer plus one), r_ptr_gray_r, error_r.
- On a clock edge with yumi_i=1 and v_o=1:
  - r_ptr_binary_r <= r_ptr_p1_r.
  - r_ptr_p1_r <= r_ptr_p1_r + 1, modulo 2^ptr_w.
  - r_ptr_gray_r <= gray(r_ptr_p1_r), where gray(x) = x ^ (x>>1).
  - The gray value is computed from a registered value, so r_ptr_gray_r_o is driven directly from flops with no combinational logic after them.
- Otherwise all pointer registers hold.
- Write pointer decode is combinational, with zero latency from the w_ptr_gray_rsync_i input:
  - w_bin[ptr_w-1] = g[ptr_w-1].
  - w_bin[i] = w_bin[i+1] ^ g[i], for i descending.
- v_o = (w_ptr_gray_rsync_i != r_ptr_gray_r). Equal gray codes mean equal pointers, which means empty.
- count_o = (w_bin - r_ptr_binary_r_o) modulo 2^ptr_w.
  - The extra MSB distinguishes full (count 2^lg_size_p) from empty (count 0).
- Read latency: after an accepting edge, r_addr_o, v_o and count_o reflect the new pointer in the same cycle, through the combinational paths above.
- Wrap-around:
  - Pointer 2^ptr_w-1 advances to 0. For ptr_w=5, 31 -> 0 with gray 10000 -> 00000.
  - r_addr_o wraps every 2^lg_size_p entries.
- yumi_i=1 while v_o=0 (underflow): pointers do not advance and error_r <= 1.
- count_o > 2^lg_size_p (overcapacity; the write pointer is inconsistent): error_r <= 1 on the next edge.
- error_o = error_r. It is sticky and cleared only by reset_i.
- Simultaneous events: a write pointer change and yumi_i in the same cycle are independent.
  - count_o uses the current input value and the current read pointer.
  - The next cycle reflects both updates.

Test Plan:
- Asynchronous reset mid-stream:
  - Stimulus: run with r_ptr_binary_r_o=7, then assert reset_i between clock edges.
  - Response: r_ptr_binary_r_o=0, r_ptr_gray_r_o=0 and error_o=0 immediately. After release, the first accept moves the pointer to 1.
- Single entry:
  - Stimulus: after reset, set w_ptr_gray_rsync_i=00001.
  - Response: v_o=1, count_o=1, r_addr_o=0.
  - Then pulse yumi_i. Next cycle: r_ptr_binary_r_o=1, r_ptr_gray_r_o=00001, v_o=0, count_o=0.
- Underflow:
  - Stimulus: with v_o=0, pulse yumi_i.
  - Response: pointers unchanged; error_o=1 from the next cycle and held through 10 further idle cycles until reset_i.
- Full drain:
  - Stimulus: with r=0, set w_ptr_gray_rsync_i=gray(16)=11000.
  - Response: count_o=16, v_o=1.
  - Then hold yumi_i for 16 cycles: r_addr_o steps 0..15; at the end r_ptr_binary_r_o=10000, r_ptr_gray_r_o=11000, r_addr_o=0, v_o=0, error_o=0.
- Wrap:
  - Stimulus: bring r_ptr_binary_r_o to 31 (gray 10000), then set the write gray to 00000.
  - Response: count_o=1, v_o=1.
  - Then pulse yumi_i: r_ptr_binary_r_o=0, r_ptr_gray_r_o=00000, v_o=0.
- Overcapacity:
  - Stimulus: with r=0, set w_ptr_gray_rsync_i=gray(17)=11001.
  - Response: count_o=17, error_o=1 on the next edge.

Source files
------------

// File: rtl/bsg_async_rptr_ctrl.sv
// rtl/bsg_async_rptr_ctrl.sv - read-side pointer controller for the dual-clock FIFO
module bsg_async_rptr_ctrl #(
  parameter int lg_size_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [lg_size_p:0] w_ptr_gray_rsync_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [lg_size_p-1:0] r_addr_o,
  output logic [lg_size_p:0] r_ptr_binary_r_o,
  output logic [lg_size_p:0] r_ptr_gray_r_o,
  output logic [lg_size_p:0] count_o,
  output logic               error_o
);

  localparam int ptr_w = lg_size_p + 1;
  // Occupancy of a completely full FIFO; anything above it is an inconsistent write pointer.
  localparam logic [ptr_w-1:0] full_count = {1'b1, {lg_size_p{1'b0}}};

  logic [ptr_w-1:0] r_ptr_binary_r;
  logic [ptr_w-1:0] r_ptr_p1_r;
  logic [ptr_w-1:0] r_ptr_gray_r;
  logic             error_r;
  logic [ptr_w-1:0] w_bin;
  logic [ptr_w-1:0] r_ptr_p1_gray;
  logic             accept;
  logic             underflow;
  logic             overcap;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < ptr_w; i++) begin
      w_bin[i] = ^(w_ptr_gray_rsync_i >> i);
    end
  end

  assign r_ptr_p1_gray = r_ptr_p1_r ^ (r_ptr_p1_r >> 1);

  // Equal gray codes mean equal pointers, i.e. empty.
  assign v_o       = (w_ptr_gray_rsync_i != r_ptr_gray_r);
  assign count_o   = w_bin - r_ptr_binary_r;
  assign accept    = yumi_i & v_o;
  assign underflow = yumi_i & ~v_o;
  assign overcap   = (count_o > full_count);

  assign r_addr_o         = r_ptr_binary_r[lg_size_p-1:0];
  assign r_ptr_binary_r_o = r_ptr_binary_r;
  assign r_ptr_gray_r_o   = r_ptr_gray_r;
  assign error_o          = error_r;

  // Advance the binary, plus-one and gray pointers together on an accepted read.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr_binary_r <= '0;
      r_ptr_p1_r     <= ptr_w'(1);
      r_ptr_gray_r   <= '0;
    end else if (accept) begin
      r_ptr_binary_r <= r_ptr_p1_r;
      r_ptr_p1_r     <= r_ptr_p1_r + ptr_w'(1);
      r_ptr_gray_r   <= r_ptr_p1_gray;
    end
  end

  // Sticky error on underflow or an impossible occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (underflow || overcap) begin
      error_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_async_rptr_ctrl.sv
// tb/tb_bsg_async_rptr_ctrl.sv - scoreboard bench for bsg_async_rptr_ctrl
module tb_bsg_async_rptr_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [4:0] w_ptr_gray_rsync_i;
  logic       yumi_i;
  logic       v_o;
  logic [3:0] r_addr_o;
  logic [4:0] r_ptr_binary_r_o;
  logic [4:0] r_ptr_gray_r_o;
  logic [4:0] count_o;
  logic       error_o;

  bsg_async_rptr_ctrl #(.lg_size_p(4)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .w_ptr_gray_rsync_i (w_ptr_gray_rsync_i),
    .yumi_i             (yumi_i),
    .v_o                (v_o),
    .r_addr_o           (r_addr_o),
    .r_ptr_binary_r_o   (r_ptr_binary_r_o),
    .r_ptr_gray_r_o     (r_ptr_gray_r_o),
    .count_o            (count_o),
    .error_o            (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       v;
    logic [4:0] count;
    logic [3:0] addr;
    logic [4:0] rbin;
    logic [4:0] rgray;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_w     = 0;
  int   m_r     = 0;
  bit   m_err   = 1'b0;

  function automatic logic [4:0] to_gray(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int   cnt;
    cnt     = (m_w - m_r) & 31;
    e.v     = (cnt != 0);
    e.count = 5'(cnt);
    e.addr  = 4'(m_r & 15);
    e.rbin  = 5'(m_r);
    e.rgray = to_gray(m_r);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, "_v"},     int'(v_o),              int'(e.v));
    check_val({tag, "_count"}, int'(count_o),          int'(e.count));
    check_val({tag, "_addr"},  int'(r_addr_o),         int'(e.addr));
    check_val({tag, "_rbin"},  int'(r_ptr_binary_r_o), int'(e.rbin));
    check_val({tag, "_rgray"}, int'(r_ptr_gray_r_o),   int'(e.rgray));
    check_val({tag, "_err"},   int'(error_o),          int'(e.err));
  endtask

  // Drive one cycle of stimulus from a negedge, check the pre-edge outputs,
  // then advance the model across the rising edge.
  task automatic step(input string tag, input int w, input bit y);
    int cnt;
    m_w = w & 31;
    w_ptr_gray_rsync_i = to_gray(m_w);
    yumi_i = y;
    push_exp();
    #1;
    pop_check(tag);
    cnt = (m_w - m_r) & 31;
    if (y && cnt != 0) m_r = (m_r + 1) & 31;
    else if (y) m_err = 1'b1;
    if (cnt > 16) m_err = 1'b1;
    @(negedge clk_i);
  endtask

  // Assert reset between edges and check its immediate effect.
  task automatic async_reset(input string tag);
    reset_i = 1'b1;
    m_r = 0;
    m_err = 1'b0;
    push_exp();
    #1;
    pop_check(tag);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    yumi_i = 1'b0;
    w_ptr_gray_rsync_i = 5'd0;
    #2;
    push_exp();
    pop_check("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    // Single entry
    step("single_avail", 1, 1'b0);
    step("single_pop", 1, 1'b1);
    step("single_after", 1, 1'b0);

    // Underflow, then the error must stick through idle cycles
    step("uflow", 1, 1'b1);
    for (int i = 0; i < 10; i++) step("uflow_hold", 1, 1'b0);
    async_reset("uflow_reset");
    m_w = 0;
    step("uflow_clear", 0, 1'b0);

    // Full drain
    step("full", 16, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 16, 1'b1);
    step("drained", 16, 1'b0);

    // Wrap from 31 to 0
    for (int i = 0; i < 15; i++) step("to31", 31, 1'b1);
    step("at31", 31, 1'b0);
    step("wrap_avail", 32, 1'b0);
    step("wrap_pop", 32, 1'b1);
    step("wrapped", 32, 1'b0);

    // Asynchronous reset mid-stream at pointer 7
    for (int i = 0; i < 7; i++) step("to7", 10, 1'b1);
    step("at7", 10, 1'b0);
    async_reset("mid_reset");
    step("post_reset_pop", 10, 1'b1);
    step("post_reset", 10, 1'b0);

    // Overcapacity
    async_reset("ovc_reset");
    step("ovc", 17, 1'b0);
    step("ovc_err", 17, 1'b0);
    async_reset("ovc_clear");

    // Mixed traffic: write pointer creeps ahead while the consumer pops at random
    for (int i = 0; i < 60; i++) begin
      int w;
      w = m_w;
      if (((w - m_r) & 31) < 16 && $urandom_range(0, 1) == 1) w = w + 1;
      step("mixed", w, ((w - m_r) & 31) != 0 && $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
